// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b memory arbiter: word/mask aliases, arbiter FSM state,
// fetch-starvation streak counter and the captured downstream request.
package lc3b_mem_arbiter_pkg;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;
   typedef logic [3:0]  lc3b_arb_streak;

   typedef enum logic [1:0] {
      arb_idle    = 2'd0,
      arb_serve_i = 2'd1,
      arb_serve_d = 2'd2
   } lc3b_arb_state;

   typedef struct packed {
      logic          read;
      logic          write;
      lc3b_word      addr;
      lc3b_word      wdata;
      lc3b_mem_wmask wmask;
   } lc3b_mem_req;

   // Saturating increment of the data-grant streak.
   function automatic lc3b_arb_streak streak_inc(input lc3b_arb_streak cur,
                                                 input lc3b_arb_streak max);
      return (cur >= max) ? max : cur + lc3b_arb_streak'(1);
   endfunction

endpackage

// File: rtl/lc3b_mem_arbiter_pick.sv
// Combinational grant picker: data wins unless fetch has waited through
// MAX_D_STREAK consecutive data grants.
module lc3b_arb_pick
   import lc3b_mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic           i_read,
   input  logic           d_req,
   input  lc3b_arb_streak streak,
   output logic           grant_i,
   output logic           grant_d
);

   localparam lc3b_arb_streak MaxStreak = lc3b_arb_streak'(MAX_D_STREAK);

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (d_req && (!i_read || (streak < MaxStreak))) begin
         grant_d = 1'b1;
      end else if (i_read) begin
         grant_i = 1'b1;
      end
   end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access: captures one
// request per grant, holds it until mem_resp, and routes the response to its owner.
module lc3b_mem_arbiter
   import lc3b_mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_read,
   input  logic [15:0]   i_addr,
   output logic [15:0]   i_rdata,
   output logic          i_resp,
   input  logic          d_read,
   input  logic          d_write,
   input  logic [15:0]   d_addr,
   input  logic [15:0]   d_wdata,
   input  logic [1:0]    d_wmask,
   output logic [15:0]   d_rdata,
   output logic          d_resp,
   output logic          mem_read,
   output logic          mem_write,
   output logic [15:0]   mem_addr,
   output logic [15:0]   mem_wdata,
   output logic [1:0]    mem_wmask,
   input  logic [15:0]   mem_rdata,
   input  logic          mem_resp,
   output logic          proto_err
);

   localparam lc3b_arb_streak MaxStreak = lc3b_arb_streak'(MAX_D_STREAK);

   lc3b_arb_state  state_q, state_d;
   lc3b_arb_streak streak_q, streak_d;
   lc3b_mem_req    req_q, req_d;
   logic           proto_err_q, proto_err_d;
   logic           d_req;
   logic           grant_i;
   logic           grant_d;

   assign d_req = d_read | d_write;

   lc3b_arb_pick #(
      .MAX_D_STREAK(MAX_D_STREAK)
   ) u_pick (
      .i_read (i_read),
      .d_req  (d_req),
      .streak (streak_q),
      .grant_i(grant_i),
      .grant_d(grant_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= arb_idle;
      end else begin
         state_q <= state_d;
      end
   end

   // Grants are only evaluated in IDLE; a mem_resp seen in IDLE is ignored.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         arb_idle: begin
            if (grant_d) begin
               state_d = arb_serve_d;
            end else if (grant_i) begin
               state_d = arb_serve_i;
            end
         end
         arb_serve_i, arb_serve_d: begin
            if (mem_resp) begin
               state_d = arb_idle;
            end
         end
         default: state_d = arb_idle;
      endcase
   end

   always_comb begin
      i_resp    = mem_resp & (state_q == arb_serve_i);
      d_resp    = mem_resp & (state_q == arb_serve_d);
      i_rdata   = mem_rdata;
      d_rdata   = mem_rdata;
      mem_read  = req_q.read;
      mem_write = req_q.write;
      mem_addr  = req_q.addr;
      mem_wdata = req_q.wdata;
      mem_wmask = req_q.wmask;
      proto_err = proto_err_q;
   end

   // A simultaneous d_read/d_write is served as a write and flagged.
   always_comb begin
      req_d       = req_q;
      streak_d    = streak_q;
      proto_err_d = 1'b0;
      if (state_q == arb_idle) begin
         if (grant_d) begin
            req_d.read  = ~d_write;
            req_d.write = d_write;
            req_d.addr  = d_addr;
            req_d.wdata = d_wdata;
            req_d.wmask = d_write ? d_wmask : 2'b00;
            proto_err_d = d_read & d_write;
            streak_d    = i_read ? streak_inc(streak_q, MaxStreak) : '0;
         end else if (grant_i) begin
            req_d.read  = 1'b1;
            req_d.write = 1'b0;
            req_d.addr  = i_addr;
            req_d.wdata = '0;
            req_d.wmask = 2'b00;
            streak_d    = '0;
         end
      end else if (mem_resp) begin
         req_d.read  = 1'b0;
         req_d.write = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q       <= '0;
         streak_q    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         req_q       <= req_d;
         streak_q    <= streak_d;
         proto_err_q <= proto_err_d;
      end
   end

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Scoreboard bench for lc3b_mem_arbiter: stimulus queues expected downstream
// transactions, a negedge monitor pops and checks them on each new strobe and resp.
module tb_lc3b_mem_arbiter;
   import lc3b_mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_read = 1'b0;
   logic [15:0] i_addr = '0;
   logic [15:0] i_rdata;
   logic        i_resp;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic [1:0]  d_wmask = '0;
   logic [15:0] d_rdata;
   logic        d_resp;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_wmask;
   logic [15:0] mem_rdata = '0;
   logic        mem_resp = 1'b0;
   logic        proto_err;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [1:0]  wmask;
      logic        perr;
      logic        owner_d;
      logic        chk_rdata;
      logic [15:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   logic cur_valid = 1'b0;
   logic mon_prev = 1'b0;
   logic stray_req = 1'b0;
   int   mem_cnt = 0;
   int   checks = 0;
   int   errors = 0;

   lc3b_mem_arbiter #(.MAX_D_STREAK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
      .mem_resp(mem_resp), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [1:0] wmask, input logic perr, input logic owner_d,
                               input logic chk_rdata, input logic [15:0] rdata);
      exp_t e;
      e.wr = wr; e.addr = addr; e.wdata = wdata; e.wmask = wmask; e.perr = perr;
      e.owner_d = owner_d; e.chk_rdata = chk_rdata; e.rdata = rdata;
      return e;
   endfunction

   // Memory model: reads return addr ^ 16'h2234, resp in the 4th strobe cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            mem_resp = 1'b0;
            mem_cnt  = 0;
         end else if (mem_read | mem_write) begin
            if (mem_resp) begin
               mem_resp = 1'b0;
               mem_cnt  = 0;
            end else begin
               mem_cnt++;
               if (mem_cnt == 4) begin
                  mem_resp  = 1'b1;
                  mem_rdata = mem_addr ^ 16'h2234;
               end
            end
         end else begin
            mem_cnt   = 0;
            mem_resp  = stray_req;
            mem_rdata = 16'hDEAD;
         end
      end
   end

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_prev  = 1'b0;
            cur_valid = 1'b0;
         end else begin
            if ((mem_read | mem_write) && !mon_prev) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_grant actual addr=%0h required none", mem_addr);
               end else begin
                  cur = exp_q.pop_front();
                  cur_valid = 1'b1;
                  chk("grant_write", mem_write, cur.wr);
                  chk("grant_read", mem_read, !cur.wr);
                  chk("grant_addr", mem_addr, cur.addr);
                  if (cur.wr) chk("grant_wdata", mem_wdata, cur.wdata);
                  chk("grant_wmask", mem_wmask, cur.wmask);
                  chk("grant_proto_err", proto_err, cur.perr);
               end
            end else if (proto_err) begin
               chk("stray_proto_err", proto_err, 1'b0);
            end
            if (i_resp | d_resp) begin
               if (!cur_valid) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp actual i=%0b d=%0b required none", i_resp, d_resp);
               end else begin
                  chk("resp_i", i_resp, !cur.owner_d);
                  chk("resp_d", d_resp, cur.owner_d);
                  if (cur.chk_rdata) chk("resp_rdata", cur.owner_d ? d_rdata : i_rdata, cur.rdata);
                  $display("txn owner=%s %s addr=%04h wdata=%04h wmask=%02b rdata=%04h",
                           cur.owner_d ? "D" : "I", cur.wr ? "WR" : "RD", cur.addr,
                           cur.wdata, cur.wmask, cur.owner_d ? d_rdata : i_rdata);
                  cur_valid = 1'b0;
               end
            end
            mon_prev = mem_read | mem_write;
         end
      end
   end

   task automatic fetch(input logic [15:0] addr);
      logic got = 1'b0;
      i_addr = addr;
      i_read = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (i_resp) begin got = 1'b1; break; end
      end
      if (!got) chk("fetch_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      i_read = 1'b0;
   endtask

   task automatic dreq(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] wmask);
      logic got = 1'b0;
      d_addr = addr; d_wdata = wdata; d_wmask = wmask;
      d_read = rd; d_write = wr;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (d_resp) begin got = 1'b1; break; end
      end
      if (!got) chk("data_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      d_read = 1'b0; d_write = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_write", mem_write, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0);
      chk("rst_proto_err", proto_err, 1'b0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {i_resp, d_resp, mem_read, mem_write}, 4'b0000);

      // Single fetch with cycle-exact timing (cycle 0 = request cycle)
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b0, 16'h3000, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1234));
      i_addr = 16'h3000; i_read = 1'b1;
      @(negedge clk); chk("fetch_c0_no_strobe", mem_read, 1'b0);
      @(negedge clk); chk("fetch_c1_strobe", mem_read, 1'b1);
      chk("fetch_c1_addr", mem_addr, 16'h3000);
      @(negedge clk);
      @(negedge clk); chk("fetch_c3_no_resp", i_resp, 1'b0);
      @(negedge clk); chk("fetch_c4_resp", i_resp, 1'b1);
      chk("fetch_c4_rdata", i_rdata, 16'h1234);
      @(posedge clk); #1; i_read = 1'b0;
      @(negedge clk); chk("fetch_c5_drop", mem_read, 1'b0);

      // Simultaneous: data first, then fetch
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b1, 16'h4002, 16'hBEEF, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0));
      exp_q.push_back(mk(1'b0, 16'h3002, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1236));
      fork
         fetch(16'h3002);
         dreq(1'b0, 1'b1, 16'h4002, 16'hBEEF, 2'b10);
      join

      // Starvation bound: 4 data grants, 1 fetch, then data resumes
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b0, 16'h4010, 16'h0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h6224));
      exp_q.push_back(mk(1'b0, 16'h4012, 16'h0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h6226));
      exp_q.push_back(mk(1'b0, 16'h4014, 16'h0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h6220));
      exp_q.push_back(mk(1'b0, 16'h4016, 16'h0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h6222));
      exp_q.push_back(mk(1'b0, 16'h3004, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1230));
      exp_q.push_back(mk(1'b0, 16'h4018, 16'h0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h622C));
      exp_q.push_back(mk(1'b0, 16'h401A, 16'h0, 2'b00, 1'b0, 1'b1, 1'b1, 16'h622E));
      fork
         fetch(16'h3004);
         begin
            d_addr = 16'h4010; d_wmask = 2'b11; d_read = 1'b1;
            for (int n = 0; n < 6; n++) begin
               logic got = 1'b0;
               for (int c = 0; c < 100; c++) begin
                  @(negedge clk);
                  if (d_resp) begin got = 1'b1; break; end
               end
               if (!got) chk("streak_timeout", 32'd0, 32'd1);
               @(posedge clk); #1;
               if (n == 5) d_read = 1'b0;
               else d_addr = d_addr + 16'h2;
            end
         end
      join

      // Illegal read+write: served as write, proto_err on first strobe cycle
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b1, 16'h4020, 16'h1357, 2'b11, 1'b1, 1'b1, 1'b0, 16'h0));
      dreq(1'b1, 1'b1, 16'h4020, 16'h1357, 2'b11);

      // Stray response in IDLE
      @(negedge clk); stray_req = 1'b1;
      @(posedge clk); #2; stray_req = 1'b0;
      @(negedge clk);
      chk("stray_i_resp", i_resp, 1'b0);
      chk("stray_d_resp", d_resp, 1'b0);
      @(negedge clk);
      chk("stray_no_strobe", {mem_read, mem_write}, 2'b00);
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b0, 16'h3006, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1232));
      fetch(16'h3006);

      // Asynchronous reset in the middle of a data write
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b1, 16'h4030, 16'h2468, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0));
      d_addr = 16'h4030; d_wdata = 16'h2468; d_wmask = 2'b01; d_write = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2; rst_n = 1'b0;
      #1;
      chk("arst_mem_write", mem_write, 1'b0);
      chk("arst_mem_read", mem_read, 1'b0);
      chk("arst_mem_addr", mem_addr, 16'h0);
      chk("arst_mem_wdata", mem_wdata, 16'h0);
      chk("arst_mem_wmask", mem_wmask, 2'b00);
      chk("arst_resp", {i_resp, d_resp}, 2'b00);
      d_write = 1'b0;
      @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b0, 16'h3008, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h123C));
      i_addr = 16'h3008; i_read = 1'b1;
      @(negedge clk);
      @(negedge clk); chk("post_arst_grant_latency", mem_read, 1'b1);
      i_read = 1'b1;
      fetch(16'h3008);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
